planar_shifter_gen: RTL and testbench

- Parametrised successor to the ST shifter video path: converts interleaved bitplane words from the MMU/DMA into one colour index per pixel strobe.
- Generalised in plane count and word width; mode selects how many planes are active.
- Adds an STE-style per-line fine horizontal scroll, a double-buffered group register, and underrun/overrun reporting.
- Sits between the video DMA data bus and the palette lookup, in the clksys domain.

---
 rtl/planar_shifter_gen.sv | 141 ++++++++++++++
 tb/tb_planar_shifter_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/planar_shifter_gen.sv
// Bitplane-to-pixel shifter: gathers AP plane words per group into a double-buffered
// hold register and shifts one colour index out per pixel strobe, with first-group fine scroll.
module planar_shifter_gen #(
    parameter int unsigned PLANES = 4,
    parameter int unsigned WORD_W = 16
) (
    input  logic                      clksys,
    input  logic                      nReset,
    input  logic                      pix_en,
    input  logic                      load_stb,
    input  logic [WORD_W-1:0]         din,
    input  logic                      de,
    input  logic [1:0]                mode,
    input  logic [$clog2(WORD_W)-1:0] hscroll,
    output logic [PLANES-1:0]         color_index,
    output logic                      pix_valid,
    output logic                      underrun,
    output logic                      overrun
);

    localparam int unsigned SW = $clog2(WORD_W);
    localparam int unsigned CW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam logic [SW-1:0] PCNT_MAX = SW'(WORD_W - 1);

    logic [WORD_W-1:0] pipe [PLANES];
    logic [WORD_W-1:0] hold [PLANES];
    logic [WORD_W-1:0] sh   [PLANES];

    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_eff;
    logic [CW-1:0] ap_m1;
    logic [SW-1:0] pcnt;
    logic [SW-1:0] scr;
    logic [SW-1:0] shamt;
    logic          ready;
    logic          active;
    logic          first;
    logic          de_q;
    logic          last_word;
    logic          reload;
    int unsigned   ap_n;

    always_comb begin
        ap_n = PLANES >> mode;
        if (ap_n == 0) begin
            ap_n = 1;
        end
        ap_m1 = CW'(ap_n - 1);
    end

    // A mode change mid-line can leave wcnt beyond the new group size; clamp it.
    assign wcnt_eff  = (wcnt > ap_m1) ? ap_m1 : wcnt;
    assign last_word = load_stb && (wcnt_eff == ap_m1);
    assign reload    = pix_en && ready && (!active || (pcnt == PCNT_MAX));
    assign shamt     = first ? scr : '0;

    always_ff @(posedge clksys or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned p = 0; p < PLANES; p++) begin
                pipe[p] <= '0;
                hold[p] <= '0;
                sh[p]   <= '0;
            end
            wcnt     <= '0;
            pcnt     <= '0;
            scr      <= '0;
            ready    <= 1'b0;
            active   <= 1'b0;
            first    <= 1'b0;
            de_q     <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            de_q     <= de;
            underrun <= 1'b0;
            overrun  <= 1'b0;

            if (reload) begin
                for (int unsigned p = 0; p < PLANES; p++) begin
                    sh[p] <= (CW'(p) <= ap_m1) ? (hold[p] << shamt) : '0;
                end
                pcnt   <= shamt;
                active <= 1'b1;
                first  <= 1'b0;
                ready  <= 1'b0;
            end else if (pix_en && active) begin
                if (pcnt == PCNT_MAX) begin
                    for (int unsigned p = 0; p < PLANES; p++) begin
                        sh[p] <= '0;
                    end
                    pcnt     <= '0;
                    active   <= 1'b0;
                    underrun <= de;
                end else begin
                    for (int unsigned p = 0; p < PLANES; p++) begin
                        sh[p] <= {sh[p][WORD_W-2:0], 1'b0};
                    end
                    pcnt <= pcnt + 1'b1;
                end
            end

            if (de && !de_q) begin
                first <= 1'b1;
                scr   <= hscroll;
            end

            // Group completion after the reload clears ready, so a same-cycle reload keeps the new group.
            if (!de) begin
                wcnt  <= '0;
                ready <= 1'b0;
            end else if (load_stb) begin
                if (last_word) begin
                    for (int unsigned p = 0; p < PLANES; p++) begin
                        if (CW'(p) < wcnt_eff) begin
                            hold[p] <= pipe[p];
                        end else if (CW'(p) == wcnt_eff) begin
                            hold[p] <= din;
                        end
                    end
                    ready <= 1'b1;
                    wcnt  <= '0;
                    if (ready && !reload) begin
                        overrun <= 1'b1;
                    end
                end else begin
                    pipe[wcnt_eff] <= din;
                    wcnt           <= wcnt_eff + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < PLANES; p++) begin
            color_index[p] = sh[p][WORD_W-1];
        end
    end

    assign pix_valid = active;

endmodule

// File: tb/tb_planar_shifter_gen.sv
// Directed self-checking bench for planar_shifter_gen (PLANES=4, WORD_W=16).
module tb_planar_shifter_gen;

    localparam int unsigned PLANES = 4;
    localparam int unsigned WORD_W = 16;

    logic              clksys = 1'b0;
    logic              nReset;
    logic              pix_en;
    logic              load_stb;
    logic [WORD_W-1:0] din;
    logic              de;
    logic [1:0]        mode;
    logic [3:0]        hscroll;
    logic [PLANES-1:0] color_index;
    logic              pix_valid;
    logic              underrun;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    planar_shifter_gen #(.PLANES(PLANES), .WORD_W(WORD_W)) dut (
        .clksys      (clksys),
        .nReset      (nReset),
        .pix_en      (pix_en),
        .load_stb    (load_stb),
        .din         (din),
        .de          (de),
        .mode        (mode),
        .hscroll     (hscroll),
        .color_index (color_index),
        .pix_valid   (pix_valid),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 clksys = ~clksys;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] d, input logic pe);
        load_stb = ld;
        din      = d;
        pix_en   = pe;
        @(posedge clksys);
        #1;
        load_stb = 1'b0;
        pix_en   = 1'b0;
    endtask

    task automatic load_group(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        step(1'b1, w0, 1'b0);
        step(1'b1, w1, 1'b0);
        step(1'b1, w2, 1'b0);
        step(1'b1, w3, 1'b0);
    endtask

    logic [15:0] pat;
    logic [3:0]  exp_c;

    initial begin
        nReset = 1'b0; pix_en = 1'b0; load_stb = 1'b0; din = '0;
        de = 1'b0; mode = 2'd0; hscroll = '0;
        repeat (2) @(posedge clksys);
        #1;
        check_val("rst_color", 16'(color_index), 16'h0);
        check_val("rst_valid", 16'(pix_valid), 16'h0);
        check_val("rst_under", 16'(underrun), 16'h0);
        check_val("rst_over", 16'(overrun), 16'h0);
        nReset = 1'b1;

        // 4 planes, unscrolled
        de = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        load_group(16'h8000, 16'h0000, 16'hFFFF, 16'h0001);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 16'h0, 1'b1);
            exp_c = (i == 0) ? 4'b0101 : ((i == 15) ? 4'b1100 : 4'b0100);
            check_val($sformatf("t1_color%0d", i), 16'(color_index), 16'(exp_c));
            check_val($sformatf("t1_valid%0d", i), 16'(pix_valid), 16'h1);
            check_val($sformatf("t1_under%0d", i), 16'(underrun), 16'h0);
        end
        step(1'b0, 16'h0, 1'b1);
        check_val("t1_end_valid", 16'(pix_valid), 16'h0);
        check_val("t1_end_under", 16'(underrun), 16'h1);
        step(1'b0, 16'h0, 1'b0);
        check_val("t1_under_pulse", 16'(underrun), 16'h0);

        // single plane
        de = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        mode = 2'd2;
        de = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'hA5A5, 1'b0);
        pat = 16'hA5A5;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check_val($sformatf("t2_color%0d", i), 16'(color_index), {15'h0, pat[15-i]});
            check_val($sformatf("t2_valid%0d", i), 16'(pix_valid), 16'h1);
        end
        step(1'b0, 16'h0, 1'b1);
        check_val("t2_end_under", 16'(underrun), 16'h1);

        // fine scroll of 3 on the first group
        de = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        mode = 2'd0;
        hscroll = 4'd3;
        de = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        load_group(16'h1000, 16'h0, 16'h0, 16'h0);
        step(1'b0, 16'h0, 1'b1);
        check_val("t3_pix0", 16'(color_index), 16'h1);
        check_val("t3_valid0", 16'(pix_valid), 16'h1);
        for (int i = 1; i < 29; i++) begin
            step((i <= 4), (i == 1) ? 16'h8001 : 16'h0, 1'b1);
            check_val($sformatf("t3_color%0d", i), 16'(color_index), 16'((i == 13) || (i == 28)));
            check_val($sformatf("t3_valid%0d", i), 16'(pix_valid), 16'h1);
            check_val($sformatf("t3_over%0d", i), 16'(overrun), 16'h0);
        end
        step(1'b0, 16'h0, 1'b1);
        check_val("t3_end_valid", 16'(pix_valid), 16'h0);
        check_val("t3_end_under", 16'(underrun), 16'h1);

        // overrun: second group overwrites the first
        load_group(16'hFFFF, 16'h0, 16'h0, 16'h0);
        check_val("t4_over_a", 16'(overrun), 16'h0);
        step(1'b1, 16'h0000, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        check_val("t4_over_b3", 16'(overrun), 16'h0);
        step(1'b1, 16'h0000, 1'b0);
        check_val("t4_over_hit", 16'(overrun), 16'h1);
        step(1'b0, 16'h0, 1'b0);
        check_val("t4_over_pulse", 16'(overrun), 16'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check_val($sformatf("t4_color%0d", i), 16'(color_index), 16'h2);
        end
        step(1'b0, 16'h0, 1'b1);
        check_val("t4_end_under", 16'(underrun), 16'h1);

        // group completes on the reload edge
        load_group(16'hFFFF, 16'h0, 16'h0, 16'h0);
        step(1'b1, 16'h0, 1'b0);
        step(1'b1, 16'h0, 1'b0);
        step(1'b1, 16'h0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b1);
        check_val("t5_color0", 16'(color_index), 16'h1);
        check_val("t5_over0", 16'(overrun), 16'h0);
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check_val($sformatf("t5_color%0d", i), 16'(color_index), (i < 16) ? 16'h1 : 16'h8);
            check_val($sformatf("t5_valid%0d", i), 16'(pix_valid), 16'h1);
            check_val($sformatf("t5_over%0d", i), 16'(overrun), 16'h0);
        end
        step(1'b0, 16'h0, 1'b1);
        check_val("t5_end_valid", 16'(pix_valid), 16'h0);
        check_val("t5_end_under", 16'(underrun), 16'h1);

        // reset mid-line with a partial group pending
        hscroll = 4'd0;
        load_group(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'hFFFF, 1'b1);
        step(1'b1, 16'hFFFF, 1'b1);
        check_val("t6_pre_color", 16'(color_index), 16'hF);
        check_val("t6_pre_valid", 16'(pix_valid), 16'h1);
        nReset = 1'b0;
        #1;
        check_val("t6_rst_color", 16'(color_index), 16'h0);
        check_val("t6_rst_valid", 16'(pix_valid), 16'h0);
        @(posedge clksys);
        #1;
        nReset = 1'b1;
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        check_val("t6_partial_valid", 16'(pix_valid), 16'h0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        check_val("t6_full_valid", 16'(pix_valid), 16'h1);
        check_val("t6_full_color", 16'(color_index), 16'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
